wb_regfile: RTL and testbench

// - Integer register file that sinks the writeback-stage commit interface (rd addr/wren/data, ctrl flag).
// - Write-first bypass on decode read ports: same-cycle writeback data is visible without a hazard bubble.
// - Retire counters: committed instructions, and committed control-flow instructions (branch/JAL/JALR).
// - Registered debug read port for bench and debugger access. Sits between writeback and decode.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/wb_retire_counter.sv | 35 +++
 rtl/wb_regfile.sv | 116 +++++++++++
 tb/tb_wb_regfile.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared integer-core constants for the writeback/regfile boundary
//
// Purpose: single definition of data width, register addressing and the
// control-flow opcodes, so the writeback stage's ctrl flag and the regfile
// agree on what "control-flow" means.
// Ports: none (package).
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    // Major opcodes that count as control-flow at retire.
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    // Used by the writeback stage to produce i_wb_ctrl.
    function automatic logic is_ctrl_opcode(input logic [6:0] opc);
        return (opc == OPC_BR) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// rtl/wb_retire_counter.sv - wrapping retire event counter with synchronous clear
//
// Purpose: counts single-cycle increment events; wraps modulo 2^CNT_W.
// A clear in the same cycle as an increment wins, the event is dropped.
// Ports:
//   i_clk    in   1      clock
//   i_reset  in   1      asynchronous, active-low reset
//   i_clr    in   1      synchronous clear
//   i_inc    in   1      increment by one this edge
//   o_cnt    out  CNT_W  current count
module wb_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - integer register file with write-first bypass and retire counters
//
// Purpose: sinks the writeback commit interface, serves two combinational
// decode read ports (same-cycle writeback data forwarded), a registered
// debug read port, and instret / control-flow retire counters.
// Ports:
//   i_clk, i_reset              clock, asynchronous active-low reset
//   i_wb_valid/rd_wren/rd_addr  writeback slot valid, write enable, destination
//   i_wb_data_wb, i_wb_ctrl     writeback data, control-flow flag
//   i_rs1_addr/o_rs1_data       decode read port 1 (combinational)
//   i_rs2_addr/o_rs2_data       decode read port 2 (combinational)
//   i_dbg_addr/o_dbg_data       debug read port (1-cycle latency)
//   i_cnt_clr                   synchronous clear of both counters
//   o_instret, o_ctrl_ret       committed / committed control-flow counts
module wb_regfile
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREG  = rv_pkg::NREG,
    parameter int CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_valid,
    input  logic                  i_wb_rd_wren,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]       i_wb_data_wb,
    input  logic                  i_wb_ctrl,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    output logic [XLEN-1:0]       o_dbg_data,
    input  logic                  i_cnt_clr,
    output logic [CNT_W-1:0]      o_instret,
    output logic [CNT_W-1:0]      o_ctrl_ret
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] r_dbg_data;
    logic            w_commit;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_dbg_data;

    // Qualified by reset so that, while reset is held, the bypass path
    // cannot leak writeback data onto the read ports.
    assign w_commit = i_reset & i_wb_valid & i_wb_rd_wren & (i_wb_rd_addr != REG_X0);

    // Write-first read: x0 is zero, a matching commit forwards its data,
    // otherwise the stored value.
    function automatic logic [XLEN-1:0] f_read(
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  commit,
        input logic [REG_ADDR_W-1:0] wr_addr,
        input logic [XLEN-1:0]       wr_data,
        input logic [XLEN-1:0]       stored
    );
        if (addr == REG_X0) begin
            return '0;
        end else if (commit && (addr == wr_addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        w_rs1_data = f_read(i_rs1_addr, w_commit, i_wb_rd_addr, i_wb_data_wb, r_regs[i_rs1_addr]);
        w_rs2_data = f_read(i_rs2_addr, w_commit, i_wb_rd_addr, i_wb_data_wb, r_regs[i_rs2_addr]);
        w_dbg_data = f_read(i_dbg_addr, w_commit, i_wb_rd_addr, i_wb_data_wb, r_regs[i_dbg_addr]);
    end

    assign o_rs1_data = w_rs1_data;
    assign o_rs2_data = w_rs2_data;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[i_wb_rd_addr] <= i_wb_data_wb;
        end
    end

    // Capturing the bypassed value makes the debug read at edge E reflect
    // the write performed at that same edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= w_dbg_data;
        end
    end

    assign o_dbg_data = r_dbg_data;

    wb_retire_counter #(.CNT_W(CNT_W)) u_instret (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_cnt_clr),
        .i_inc   (i_wb_valid),
        .o_cnt   (o_instret)
    );

    wb_retire_counter #(.CNT_W(CNT_W)) u_ctrl_ret (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (i_cnt_clr),
        .i_inc   (i_wb_valid & i_wb_ctrl),
        .o_cnt   (o_ctrl_ret)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed table-driven bench for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_wren;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ctrl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dbg_addr;
    logic        cnt_clr;
    logic [31:0] rs1_data, rs2_data, dbg_data, instret, ctrl_ret;
    logic [31:0] rs1_data4, rs2_data4, dbg_data4;
    logic [3:0]  instret4, ctrl_ret4;

    int n_vec  = 0;
    int n_fail = 0;

    wb_regfile u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_valid(wb_valid), .i_wb_rd_wren(wb_wren), .i_wb_rd_addr(wb_rd),
        .i_wb_data_wb(wb_data), .i_wb_ctrl(wb_ctrl),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data),
        .i_cnt_clr(cnt_clr), .o_instret(instret), .o_ctrl_ret(ctrl_ret)
    );

    wb_regfile #(.CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst),
        .i_wb_valid(wb_valid), .i_wb_rd_wren(wb_wren), .i_wb_rd_addr(wb_rd),
        .i_wb_data_wb(wb_data), .i_wb_ctrl(wb_ctrl),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_data4), .o_rs2_data(rs2_data4),
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data4),
        .i_cnt_clr(cnt_clr), .o_instret(instret4), .o_ctrl_ret(ctrl_ret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        wren;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic        clr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_dbg;
        logic [31:0] e_inst;
        logic [31:0] e_ctrl;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d,
                         input logic c, input logic clr);
        wb_valid = v; wb_wren = w; wb_rd = rd; wb_data = d; wb_ctrl = c; cnt_clr = clr;
    endtask

    // Apply inputs now, clock one edge, land 1 time unit after it.
    task automatic step(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d,
                        input logic c, input logic clr);
        drive(v, w, rd, d, c, clr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  5'd0,  5'd5,  1'b0,
                    32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'd1, 32'd0};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd5,  5'd5,  1'b0,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 32'd0};
        vecs[2] = '{1'b1, 1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0,
                    32'h0, 32'h0, 32'h0, 32'd2, 32'd0};
        vecs[3] = '{1'b0, 1'b1, 5'd7,  32'hFFFF0000, 1'b1, 5'd7,  5'd5,  5'd7,  1'b0,
                    32'h0, 32'hDEADBEEF, 32'h0, 32'd2, 32'd0};
        vecs[4] = '{1'b1, 1'b0, 5'd7,  32'h11111111, 1'b1, 5'd7,  5'd7,  5'd7,  1'b0,
                    32'h0, 32'h0, 32'h0, 32'd3, 32'd1};
        vecs[5] = '{1'b1, 1'b1, 5'd9,  32'hCAFEF00D, 1'b1, 5'd9,  5'd9,  5'd9,  1'b0,
                    32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'd4, 32'd2};
        vecs[6] = '{1'b1, 1'b1, 5'd9,  32'h00000042, 1'b0, 5'd9,  5'd5,  5'd9,  1'b0,
                    32'h00000042, 32'hDEADBEEF, 32'h00000042, 32'd5, 32'd2};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  5'd7,  5'd0,  1'b0,
                    32'h00000042, 32'h0, 32'h0, 32'd5, 32'd2};
        vecs[8] = '{1'b1, 1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 5'd9,  5'd31, 1'b1,
                    32'h80000001, 32'h00000042, 32'h80000001, 32'd0, 32'd0};
        vecs[9] = '{1'b1, 1'b1, 5'd31, 32'h00000007, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0,
                    32'h7, 32'h7, 32'h7, 32'd1, 32'd0};

        rst = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rs1_addr = 5'd5; rs2_addr = 5'd9; dbg_addr = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rs1",      rs1_data, 32'h0);
        chk("reset_dbg",      dbg_data, 32'h0);
        chk("reset_instret",  instret,  32'h0);
        chk("reset_ctrl_ret", ctrl_ret, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].wren, vecs[i].rd, vecs[i].data, vecs[i].ctrl, vecs[i].clr);
            rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2; dbg_addr = vecs[i].dbg;
            @(negedge clk);
            chk($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_rs1);
            chk($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_rs2);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dbg", i),      dbg_data, vecs[i].e_dbg);
            chk($sformatf("v%0d_instret", i),  instret,  vecs[i].e_inst);
            chk($sformatf("v%0d_ctrl_ret", i), ctrl_ret, vecs[i].e_ctrl);
        end

        // Counters to 9/4, then clear colliding with a valid ctrl commit.
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 5'd0, 32'h0, (i < 4), 1'b0);
        chk("pre_clr_instret",  instret,  32'd9);
        chk("pre_clr_ctrl_ret", ctrl_ret, 32'd4);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        chk("clr_wins_instret",  instret,  32'd0);
        chk("clr_wins_ctrl_ret", ctrl_ret, 32'd0);
        chk("clr_wins_instret4", {28'h0, instret4}, 32'd0);

        // 17 commits, 3 control-flow: the 4-bit instret wraps to 1.
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 5'd0, 32'h0, (i % 6 == 0), 1'b0);
        chk("wrap_instret4",  {28'h0, instret4},  32'd1);
        chk("wrap_ctrl_ret4", {28'h0, ctrl_ret4}, 32'd3);
        chk("wrap_instret32", instret,            32'd17);
        // All-ones + 1 -> 0: 14 more commits take 4-bit instret from 1 to 15, one more to 0.
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("ones_instret4", {28'h0, instret4}, 32'd15);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        chk("ones_wrap_instret4", {28'h0, instret4}, 32'd0);

        // Write x3, then reset mid-cycle while another x3 commit is driven.
        rs1_addr = 5'd3; rs2_addr = 5'd3; dbg_addr = 5'd3;
        step(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("x3_stored", rs1_data, 32'hA5A5A5A5);
        chk("x3_dbg",    dbg_data, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 5'd3, 32'h5A5A5A5A, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_rs1",      rs1_data, 32'h0);
        chk("rst_rs2",      rs2_data, 32'h0);
        chk("rst_dbg",      dbg_data, 32'h0);
        chk("rst_instret",  instret,  32'h0);
        chk("rst_ctrl_ret", ctrl_ret, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_held_rs1", rs1_data, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rs1", rs1_data, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_dbg",     dbg_data, 32'h0);
        chk("post_rst_instret", instret,  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
